// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: multi-cycle MULT/MULTU (and DIV/DIVU when
// MDU_DIV_EN is defined) plus MTHI/MTLO, HI/LO storage and pipeline stall request.
//
// state | meaning
// IDLE  | no operation pending; accepts start
// RUN   | mult/div in progress; counter counts down to result write
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        md_use,
    input  logic        hilo_sel,
    output logic        busy,
    output logic        stall,
    output logic [31:0] MDOut
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [31:0]   hi, hi_nxt, lo, lo_nxt;
    logic [31:0]   a_q, a_nxt, b_q, b_nxt;
    logic [1:0]    op_q, op_nxt;

    // op bit 0 set means unsigned for both the mult and div pairs
    logic          mul_sgn;
    logic [63:0]   ext_a, ext_b, prod;

    always_comb begin
        mul_sgn = ~op_q[0];
        ext_a   = {{32{mul_sgn & a_q[31]}}, a_q};
        ext_b   = {{32{mul_sgn & b_q[31]}}, b_q};
        prod    = ext_a * ext_b;
    end

`ifdef MDU_DIV_EN
    logic        a_neg, b_neg;
    logic [31:0] a_abs, b_abs, q_u, r_u, quo, rem;

    // Magnitude divide then fix signs: quotient truncates toward zero,
    // remainder follows the dividend. 0x80000000 / -1 wraps to 0x80000000.
    always_comb begin
        a_neg = mul_sgn & a_q[31];
        b_neg = mul_sgn & b_q[31];
        a_abs = a_neg ? -a_q : a_q;
        b_abs = b_neg ? -b_q : b_q;
        q_u   = (b_abs == 32'd0) ? 32'd0 : a_abs / b_abs;
        r_u   = (b_abs == 32'd0) ? 32'd0 : a_abs % b_abs;
        quo   = (a_neg ^ b_neg) ? -q_u : q_u;
        rem   = a_neg ? -r_u : r_u;
    end
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        hi_nxt    = hi;
        lo_nxt    = lo;
        a_nxt     = a_q;
        b_nxt     = b_q;
        op_nxt    = op_q;
        case (state)
            IDLE: begin
                if (start) begin
                    case (op)
                        3'd0, 3'd1: begin
                            a_nxt     = A;
                            b_nxt     = B;
                            op_nxt    = op[1:0];
                            cnt_nxt   = CW'(MULT_CYCLES);
                            state_nxt = RUN;
                        end
`ifdef MDU_DIV_EN
                        3'd2, 3'd3: begin
                            a_nxt     = A;
                            b_nxt     = B;
                            op_nxt    = op[1:0];
                            cnt_nxt   = CW'(DIV_CYCLES);
                            state_nxt = RUN;
                        end
`endif
                        3'd4:    hi_nxt = A;
                        3'd5:    lo_nxt = A;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_nxt = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_nxt = IDLE;
                    if (!op_q[1]) begin
                        hi_nxt = prod[63:32];
                        lo_nxt = prod[31:0];
                    end
`ifdef MDU_DIV_EN
                    else if (b_q != 32'd0) begin
                        hi_nxt = rem;
                        lo_nxt = quo;
                    end
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            hi    <= hi_nxt;
            lo    <= lo_nxt;
            a_q   <= a_nxt;
            b_q   <= b_nxt;
            op_q  <= op_nxt;
        end
    end

    assign busy  = (state == RUN);
    assign stall = md_use & (busy | (start & (op <= 3'd3)));
    assign MDOut = hilo_sel ? hi : lo;

endmodule
